// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if -- signal bundle between the hazard controller and the
// surrounding pipeline (decode fields, EX results, data-memory handshake, and
// the PC / pipeline-register control it produces).
//
// Modports:
//   slave  : the hazard controller (consumes pipeline state, drives control)
//   master : the pipeline side (drives pipeline state, consumes control)
//
// Signals:
//   id_opcode_i/id_rs1_i/id_rs2_i   fields of the instruction in ID
//   ex_opcode_i/ex_rd_i             ID/EX register outputs
//   ex_jump_i/ex_jump_addr_i        taken branch / jump resolved in EX, target
//   mem_req_i/mem_ready_i           data-memory access pending / completes
//   pc_hold_o, pc_jump_o, pc_jump_addr_o
//   ifid_en_o, idex_en_o, ifid_flush_o, idex_flush_o
//   err_o                           memory-timeout pulse
//   stall_cnt_o/flush_cnt_o         performance counters
interface pipe_hazard_ctrl_if;
  logic [6:0]  id_opcode_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [6:0]  ex_opcode_i;
  logic [4:0]  ex_rd_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        mem_req_i;
  logic        mem_ready_i;
  logic        pc_hold_o;
  logic        pc_jump_o;
  logic [31:0] pc_jump_addr_o;
  logic        ifid_en_o;
  logic        idex_en_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport slave (
    input  id_opcode_i, id_rs1_i, id_rs2_i, ex_opcode_i, ex_rd_i,
           ex_jump_i, ex_jump_addr_i, mem_req_i, mem_ready_i,
    output pc_hold_o, pc_jump_o, pc_jump_addr_o, ifid_en_o, idex_en_o,
           ifid_flush_o, idex_flush_o, err_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output id_opcode_i, id_rs1_i, id_rs2_i, ex_opcode_i, ex_rd_i,
           ex_jump_i, ex_jump_addr_i, mem_req_i, mem_ready_i,
    input  pc_hold_o, pc_jump_o, pc_jump_addr_o, ifid_en_o, idex_en_o,
           ifid_flush_o, idex_flush_o, err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard / sequencing controller for the five-stage core.
// Produces PC hold / redirect and the capture-enable and flush controls of the
// IF/ID and ID/EX registers for three conditions, highest priority first:
// jump/taken branch in EX, data-memory wait, load-use hazard.
//
// Ports:
//   clk   core clock, rising edge
//   rest  asynchronous active-low reset; while low every output reads 0
//   bus   pipe_hazard_ctrl_if.slave (pipeline fields in, control out)
//
// Parameters:
//   FLUSH_CYCLES  extra bubble cycles after a redirect (0-15)
//   MEM_TIMEOUT   MEM_WAIT cycles before the access is abandoned (1-255)
//
// Build option: define PIPE_CTRL_PERF_EN to build the saturating stall/flush
// performance counters; otherwise both counter ports read 0.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rest,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES);
  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  state_t      state_q, state_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  wcnt_q, wcnt_d;

  logic        rs1_used, rs2_used, load_use;
  logic        hold_raw, jump_raw, ifid_en_raw, idex_en_raw;
  logic        ifid_flush_raw, idex_flush_raw, err_raw;
  logic [31:0] addr_raw;
  logic        pc_hold, idex_flush;

  // Only instructions that actually read rs1/rs2 can hit a load-use hazard.
  always_comb begin
    rs1_used = !((bus.id_opcode_i == OP_LUI) || (bus.id_opcode_i == OP_AUIPC) ||
                 (bus.id_opcode_i == OP_JAL));
    rs2_used = (bus.id_opcode_i == OP_R) || (bus.id_opcode_i == OP_S) ||
               (bus.id_opcode_i == OP_B);
    load_use = (bus.ex_opcode_i == OP_LOAD) && (bus.ex_rd_i != 5'd0) &&
               (((bus.ex_rd_i == bus.id_rs1_i) && rs1_used) ||
                ((bus.ex_rd_i == bus.id_rs2_i) && rs2_used));
  end

  always_comb begin
    hold_raw       = 1'b0;
    jump_raw       = 1'b0;
    addr_raw       = 32'h0;
    ifid_en_raw    = 1'b1;
    idex_en_raw    = 1'b1;
    ifid_flush_raw = 1'b0;
    idex_flush_raw = 1'b0;
    err_raw        = 1'b0;
    state_d        = state_q;
    bcnt_d         = bcnt_q;
    wcnt_d         = wcnt_q;
    case (state_q)
      RUN: begin
        if (bus.ex_jump_i) begin
          // A jump also kills any access pending at the same time.
          jump_raw       = 1'b1;
          addr_raw       = bus.ex_jump_addr_i;
          ifid_flush_raw = 1'b1;
          idex_flush_raw = 1'b1;
          if (FLUSH_INIT != 4'd0) begin
            state_d = FLUSH;
            bcnt_d  = FLUSH_INIT;
          end
        end else if (bus.mem_req_i && !bus.mem_ready_i) begin
          hold_raw    = 1'b1;
          ifid_en_raw = 1'b0;
          idex_en_raw = 1'b0;
          state_d     = MEM_WAIT;
          wcnt_d      = 8'd1;
        end else if (load_use) begin
          // Freeze IF/ID and PC, push one bubble into ID/EX.
          hold_raw       = 1'b1;
          ifid_en_raw    = 1'b0;
          idex_flush_raw = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush_raw = 1'b1;
        idex_flush_raw = 1'b1;
        bcnt_d         = bcnt_q - 4'd1;
        if (bcnt_q <= 4'd1) begin
          state_d = RUN;
          bcnt_d  = 4'd0;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready_i) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else begin
          hold_raw    = 1'b1;
          ifid_en_raw = 1'b0;
          idex_en_raw = 1'b0;
          if (wcnt_q >= TIMEOUT_VAL) begin
            err_raw = 1'b1;
            state_d = RUN;
            wcnt_d  = 8'd0;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= RUN;
      bcnt_q  <= 4'd0;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Outputs are combinational, but held at 0 for as long as reset is low.
  assign pc_hold    = rest & hold_raw;
  assign idex_flush = rest & idex_flush_raw;

  assign bus.pc_hold_o      = pc_hold;
  assign bus.pc_jump_o      = rest & jump_raw;
  assign bus.pc_jump_addr_o = {32{rest}} & addr_raw;
  assign bus.ifid_en_o      = rest & ifid_en_raw;
  assign bus.idex_en_o      = rest & idex_en_raw;
  assign bus.ifid_flush_o   = rest & ifid_flush_raw;
  assign bus.idex_flush_o   = idex_flush;
  assign bus.err_o          = rest & err_raw;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating counters: stop at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (idex_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt_o = {32{rest}} & stall_cnt_q;
  assign bus.flush_cnt_o = {32{rest}} & flush_cnt_q;
`else
  assign bus.stall_cnt_o = 32'h0;
  assign bus.flush_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl -- directed bench for pipe_hazard_ctrl.
// u0: FLUSH_CYCLES=2, MEM_TIMEOUT=8; u1: FLUSH_CYCLES=0, MEM_TIMEOUT=1.
// Both instances see identical stimulus. Inputs change 2 time units after the
// rising edge, outputs are sampled 1 unit later (mid-cycle).
// Control vectors are packed {pc_hold, pc_jump, ifid_en, idex_en,
// ifid_flush, idex_flush, err}.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rest;

  pipe_hazard_ctrl_if b0 ();
  pipe_hazard_ctrl_if b1 ();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(8)) u0 (
    .clk (clk),
    .rest(rest),
    .bus (b0)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(0), .MEM_TIMEOUT(1)) u1 (
    .clk (clk),
    .rest(rest),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [6:0] V_OFF = 7'b0000000;
  localparam logic [6:0] V_RUN = 7'b0011000;
  localparam logic [6:0] V_LU  = 7'b1001010;
  localparam logic [6:0] V_JMP = 7'b0111110;
  localparam logic [6:0] V_FL  = 7'b0011110;
  localparam logic [6:0] V_FRZ = 7'b1000000;
  localparam logic [6:0] V_ERR = 7'b1000001;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] PERF_ONE = 32'd1;
`else
  localparam logic [31:0] PERF_ONE = 32'd0;
`endif

  int tests_run;
  int tests_failed;

  logic [6:0] ctrl0, ctrl1;
  assign ctrl0 = {b0.pc_hold_o, b0.pc_jump_o, b0.ifid_en_o, b0.idex_en_o,
                  b0.ifid_flush_o, b0.idex_flush_o, b0.err_o};
  assign ctrl1 = {b1.pc_hold_o, b1.pc_jump_o, b1.ifid_en_o, b1.idex_en_o,
                  b1.ifid_flush_o, b1.idex_flush_o, b1.err_o};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, act);
    end
  endtask

  task automatic check_c0(input string tag, input logic [6:0] exp);
    check_val({"u0.", tag}, {25'd0, ctrl0}, {25'd0, exp});
  endtask

  task automatic check_c1(input string tag, input logic [6:0] exp);
    check_val({"u1.", tag}, {25'd0, ctrl1}, {25'd0, exp});
  endtask

  task automatic drive(input logic [6:0] id_op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] ex_op, input logic [4:0] rd, input logic jmp,
                       input logic [31:0] addr, input logic req, input logic rdy);
    b0.id_opcode_i = id_op;  b1.id_opcode_i = id_op;
    b0.id_rs1_i = rs1;       b1.id_rs1_i = rs1;
    b0.id_rs2_i = rs2;       b1.id_rs2_i = rs2;
    b0.ex_opcode_i = ex_op;  b1.ex_opcode_i = ex_op;
    b0.ex_rd_i = rd;         b1.ex_rd_i = rd;
    b0.ex_jump_i = jmp;      b1.ex_jump_i = jmp;
    b0.ex_jump_addr_i = addr; b1.ex_jump_addr_i = addr;
    b0.mem_req_i = req;      b1.mem_req_i = req;
    b0.mem_ready_i = rdy;    b1.mem_ready_i = rdy;
  endtask

  // Advance one cycle, apply new inputs, settle before sampling.
  task automatic cyc(input logic [6:0] id_op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [6:0] ex_op, input logic [4:0] rd, input logic jmp,
                     input logic [31:0] addr, input logic req, input logic rdy);
    @(posedge clk);
    #2;
    drive(id_op, rs1, rs2, ex_op, rd, jmp, addr, req, rdy);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rest         = 1'b0;
    // Jump requested while in reset: every output must still read 0.
    drive(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b1, 32'h55, 1'b0, 1'b0);
    #3;
    check_c0("reset_ctrl", V_OFF);
    check_val("u0.reset_addr", b0.pc_jump_addr_o, 32'h0);
    check_val("u0.reset_stall_cnt", b0.stall_cnt_o, 32'h0);
    check_val("u0.reset_flush_cnt", b0.flush_cnt_o, 32'h0);

    @(posedge clk);
    @(posedge clk);
    #2;
    rest = 1'b1;
    drive(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_c0("post_reset_run", V_RUN);

    // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID.
    cyc(OP_R, 5'd5, 5'd1, OP_LOAD, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("lu_rs1_stall", V_LU);
    // Bubble has advanced: EX now holds a NOP.
    cyc(OP_R, 5'd5, 5'd1, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("lu_released", V_RUN);
    check_val("u0.stall_cnt_after_lu", b0.stall_cnt_o, PERF_ONE);
    check_val("u0.flush_cnt_after_lu", b0.flush_cnt_o, PERF_ONE);
    // LW x0 never stalls.
    cyc(OP_R, 5'd0, 5'd0, OP_LOAD, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("lu_x0_nostall", V_RUN);
    // LUI does not read rs1/rs2.
    cyc(OP_LUI, 5'd5, 5'd5, OP_LOAD, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("lu_lui_nostall", V_RUN);
    // Store reads rs2.
    cyc(OP_S, 5'd2, 5'd7, OP_LOAD, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("lu_store_rs2", V_LU);
    // ADDI does not read rs2.
    cyc(OP_IMM, 5'd3, 5'd7, OP_LOAD, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("lu_addi_rs2_nostall", V_RUN);

    // Jump to 0x100: u0 flushes 3 cycles, u1 only the jump cycle.
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    check_c0("jmp_cycle", V_JMP);
    check_val("u0.jmp_addr", b0.pc_jump_addr_o, 32'h0000_0100);
    check_c1("jmp_cycle", V_JMP);
    // Load-use present but ignored by u0 in FLUSH; u1 is back in RUN.
    cyc(OP_R, 5'd5, 5'd1, OP_LOAD, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("flush1_ignores_lu", V_FL);
    check_val("u0.flush1_addr", b0.pc_jump_addr_o, 32'h0);
    check_c1("fc0_run_lu", V_LU);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("flush2", V_FL);
    check_c1("fc0_run", V_RUN);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("after_flush_run", V_RUN);

    // Memory wait: ready low for 4 cycles then high.
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_c0("mw_1", V_FRZ);
    check_c1("mw_detect", V_FRZ);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_c0("mw_2", V_FRZ);
    check_c1("timeout1_err", V_ERR);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_c0("mw_3", V_FRZ);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_c0("mw_4", V_FRZ);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_c0("mw_ready_release", V_RUN);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("mw_after", V_RUN);

    // Jump and memory wait together: jump wins.
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    check_c0("jmp_beats_mw", V_JMP);
    check_val("u0.jmp_mw_addr", b0.pc_jump_addr_o, 32'h0000_0200);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("jmp_mw_flush1", V_FL);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("jmp_mw_flush2", V_FL);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("jmp_mw_run", V_RUN);

    // Timeout on u0: detection cycle in RUN, then MEM_WAIT with wcnt=1..8;
    // err pulses on the MEM_WAIT cycle where wcnt reaches 8.
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_c0("tmo_detect", V_FRZ);
    for (int i = 1; i <= 8; i++) begin
      cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
      check_c0($sformatf("tmo_wait%0d", i), (i == 8) ? V_ERR : V_FRZ);
    end
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("tmo_back_to_run", V_RUN);

    // Reset asserted in the middle of FLUSH.
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    check_c0("rst_jmp", V_JMP);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("rst_flush1", V_FL);
    #1;
    rest = 1'b0;
    #1;
    check_c0("rst_midflush_ctrl", V_OFF);
    check_c1("rst_midflush_ctrl", V_OFF);
    check_val("u0.rst_midflush_stall_cnt", b0.stall_cnt_o, 32'h0);
    check_val("u0.rst_midflush_flush_cnt", b0.flush_cnt_o, 32'h0);
    @(posedge clk);
    #2;
    rest = 1'b1;
    #1;
    check_c0("rst_release_run", V_RUN);
    cyc(OP_IMM, 5'd0, 5'd0, OP_IMM, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_c0("rst_release_no_flush", V_RUN);
    check_val("u0.post_rst_stall_cnt", b0.stall_cnt_o, 32'h0);
    check_val("u0.post_rst_flush_cnt", b0.flush_cnt_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
